// File: rtl/and_stim_ctrl_if.sv
// Bus between the AND stimulus controller and whatever drives/observes it:
// run control, A/B stimulus, returned Y and the result counters.
interface and_stim_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic [CNT_W-1:0] num_vec;
    logic             A;
    logic             B;
    logic             Y;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic [CNT_W-1:0] first_fail_idx;

    modport master (
        input  start, num_vec, Y,
        output A, B, busy, done, pass_cnt, fail_cnt, first_fail_idx
    );

    modport slave (
        output start, num_vec, Y,
        input  A, B, busy, done, pass_cnt, fail_cnt, first_fail_idx
    );
endinterface

// File: rtl/and_stim_ctrl.sv
// Counted LFSR stimulus sequencer and self-checker for a 2-input AND datapath.
// Define AND_STIM_STOP_ON_FAIL_EN to stop issuing vectors at the first mismatch.
module and_stim_ctrl #(
    parameter int          DUT_LAT = 1,
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter int          CNT_W   = 16
) (
    input  logic           clk,
    input  logic           rst,
    and_stim_ctrl_if.master bus
);
    localparam int          STAGES   = DUT_LAT - 1;
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0) ? 16'hACE1 : SEED;

    typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_t;

    state_t                       state, state_nxt;
    logic [15:0]                  lfsr;
    logic [CNT_W-1:0]             remaining;
    logic [CNT_W-1:0]             vec_idx;
    logic [STAGES:0]              vld_pipe;
    logic [STAGES:0]              exp_pipe;
    logic [STAGES:0][CNT_W-1:0]   idx_pipe;
    logic                         accept, push, stop;
    logic                         cmp_vld, cmp_fail;
    logic                         a_q, b_q, busy_q, done_q;
    logic [CNT_W-1:0]             pass_q, fail_q, ffi_q;

    // The last pipeline stage lines up with the Y of the vector it carries.
    assign cmp_vld  = vld_pipe[STAGES];
    assign cmp_fail = cmp_vld && (bus.Y != exp_pipe[STAGES]);

`ifdef AND_STIM_STOP_ON_FAIL_EN
    assign stop = cmp_fail;
`else
    assign stop = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        push      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = (bus.num_vec == '0) ? DONE : DRIVE;
                end
            end
            DRIVE: begin
                if (stop) begin
                    state_nxt = DRAIN;
                end else begin
                    push = 1'b1;
                    if (remaining == CNT_W'(1)) state_nxt = DRAIN;
                end
            end
            // An entry still in the pipeline is compared on this edge, so leave
            // only once nothing valid remains.
            DRAIN:   if (vld_pipe == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr      <= SEED_EFF;
            remaining <= '0;
            vec_idx   <= '0;
            a_q       <= 1'b0;
            b_q       <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= '0;
            fail_q    <= '0;
            ffi_q     <= '1;
            vld_pipe  <= '0;
            exp_pipe  <= '0;
            idx_pipe  <= '0;
        end else begin
            a_q    <= push & lfsr[0];
            b_q    <= push & lfsr[1];
            busy_q <= (state_nxt == DRIVE) || (state_nxt == DRAIN);
            done_q <= (state_nxt == DONE);

            if (push) begin
                lfsr      <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                remaining <= remaining - CNT_W'(1);
                vec_idx   <= vec_idx + CNT_W'(1);
            end

            vld_pipe[0] <= push;
            exp_pipe[0] <= lfsr[0] & lfsr[1];
            idx_pipe[0] <= vec_idx;
            for (int s = 1; s <= STAGES; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                exp_pipe[s] <= exp_pipe[s-1];
                idx_pipe[s] <= idx_pipe[s-1];
            end

            if (cmp_vld) begin
                if (cmp_fail) begin
                    fail_q <= fail_q + CNT_W'(1);
                    if (fail_q == '0) ffi_q <= idx_pipe[STAGES];
                end else begin
                    pass_q <= pass_q + CNT_W'(1);
                end
            end

            // Pipeline is empty in IDLE, so accept never races a compare.
            if (accept) begin
                remaining <= bus.num_vec;
                vec_idx   <= '0;
                pass_q    <= '0;
                fail_q    <= '0;
                ffi_q     <= '1;
            end
        end
    end

    assign bus.A              = a_q;
    assign bus.B              = b_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass_cnt       = pass_q;
    assign bus.fail_cnt       = fail_q;
    assign bus.first_fail_idx = ffi_q;
endmodule

// File: tb/tb_and_stim_ctrl.sv
// Directed bench for and_stim_ctrl: three instances (DUT_LAT 1, 3, 2), each
// returning Y from a delayed AND model with optional stuck-at-0 or single-vector fault.
module tb_and_stim_ctrl;
    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        st   [NI];
    logic [15:0] nv   [NI];
    int          mode [NI];
    int          fidx [NI];
    logic        a_o    [NI];
    logic        b_o    [NI];
    logic        busy_o [NI];
    logic        done_o [NI];
    logic [15:0] pass_o [NI];
    logic [15:0] fail_o [NI];
    logic [15:0] ffi_o  [NI];
    logic [15:0] mlf    [NI];

    int checks = 0;
    int errors = 0;

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 3 : 2);
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 2);
        and_stim_ctrl_if #(.CNT_W(16)) ifc ();
        logic [6:0] d    = '0;
        int         tcnt = 0;
        logic [7:0] dl;
        logic       y;

        and_stim_ctrl #(.DUT_LAT(L), .SEED(16'hACE1), .CNT_W(16)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (ifc.master)
        );

        assign ifc.start   = st[g];
        assign ifc.num_vec = nv[g];
        assign ifc.Y       = y;
        assign dl          = {d, ifc.A & ifc.B};

        // tcnt = number of edges since the accepting edge; Y for vector i is
        // presented while tcnt == i + L.
        always_comb begin
            y = dl[L-1];
            if (mode[g] == 1)                               y = 1'b0;
            else if (mode[g] == 2 && tcnt == fidx[g] + L)   y = ~dl[L-1];
        end

        always @(posedge clk) begin
            d    <= {d[5:0], ifc.A & ifc.B};
            tcnt <= st[g] ? 0 : tcnt + 1;
        end

        assign a_o[g]    = ifc.A;
        assign b_o[g]    = ifc.B;
        assign busy_o[g] = ifc.busy;
        assign done_o[g] = ifc.done;
        assign pass_o[g] = ifc.pass_cnt;
        assign fail_o[g] = ifc.fail_cnt;
        assign ffi_o[g]  = ifc.first_fail_idx;
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int g = 0; g < NI; g++) mlf[g] = 16'hACE1;
    endtask

    // Start a run and watch it; j counts cycles after the accepting edge.
    task automatic run_vec(input int g, input int n, input int drv,
                           output int done_at, output int ndone,
                           output int busy_cnt, output int ab_err);
        logic ea, eb;
        done_at = -1; ndone = 0; busy_cnt = 0; ab_err = 0;
        @(negedge clk);
        st[g] = 1'b1;
        nv[g] = n[15:0];
        for (int j = 0; j <= n + lat_of(g) + 5; j++) begin
            @(negedge clk);
            if (j == 0) st[g] = 1'b0;
            ea = 1'b0; eb = 1'b0;
            if (j >= 1 && j <= drv) begin
                ea = mlf[g][0]; eb = mlf[g][1];
                mlf[g] = lfsr_step(mlf[g]);
            end
            if (a_o[g] !== ea || b_o[g] !== eb) ab_err++;
            if (busy_o[g]) busy_cnt++;
            if (done_o[g]) begin
                ndone++;
                if (done_at < 0) done_at = j;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int g = 0; g < NI; g++) begin
            checks++;
            if ({a_o[g], b_o[g], busy_o[g], done_o[g], pass_o[g], fail_o[g], ffi_o[g]} !==
                {4'b0000, 16'h0000, 16'h0000, 16'hFFFF}) begin
                errors++;
                $display("FAIL reset_state[%0d]: got %b/%b/%b/%b %h %h %h required 0/0/0/0 0000 0000 ffff",
                         g, a_o[g], b_o[g], busy_o[g], done_o[g], pass_o[g], fail_o[g], ffi_o[g]);
            end
        end
    endtask

    task automatic test_ideal();
        int da, nd, bc, ae;
        mode[0] = 0;
        run_vec(0, 100, 100, da, nd, bc, ae);
        checks++; if (da !== 102) begin errors++; $display("FAIL ideal_done_at: got %0d required 102", da); end
        checks++; if (nd !== 1) begin errors++; $display("FAIL ideal_done_pulses: got %0d required 1", nd); end
        checks++; if (bc !== 102) begin errors++; $display("FAIL ideal_busy_cycles: got %0d required 102", bc); end
        checks++; if (pass_o[0] !== 16'd100) begin errors++; $display("FAIL ideal_pass: got %0d required 100", pass_o[0]); end
        checks++; if (fail_o[0] !== 16'd0) begin errors++; $display("FAIL ideal_fail: got %0d required 0", fail_o[0]); end
        checks++; if (ffi_o[0] !== 16'hFFFF) begin errors++; $display("FAIL ideal_first_fail: got %h required ffff", ffi_o[0]); end
        checks++; if (ae !== 0) begin errors++; $display("FAIL ideal_ab_seq: got %0d bad cycles required 0", ae); end
    endtask

    task automatic test_zero();
        int da, nd, bc, ae;
        run_vec(0, 0, 0, da, nd, bc, ae);
        checks++; if (da !== 0) begin errors++; $display("FAIL zero_done_at: got %0d required 0", da); end
        checks++; if (nd !== 1) begin errors++; $display("FAIL zero_done_pulses: got %0d required 1", nd); end
        checks++; if (bc !== 0) begin errors++; $display("FAIL zero_busy_cycles: got %0d required 0", bc); end
        checks++; if (ae !== 0) begin errors++; $display("FAIL zero_ab_idle: got %0d bad cycles required 0", ae); end
        checks++;
        if ({pass_o[0], fail_o[0], ffi_o[0]} !== {16'd0, 16'd0, 16'hFFFF}) begin
            errors++;
            $display("FAIL zero_counters: got %0d %0d %h required 0 0 ffff", pass_o[0], fail_o[0], ffi_o[0]);
        end
    endtask

    task automatic test_stuck();
        int da, nd, bc, ae;
        int ef = 0;
        int efirst = -1;
        logic [15:0] s = mlf[0];
        logic [15:0] efirst16;
        for (int i = 0; i < 64; i++) begin
            if (s[0] & s[1]) begin
                if (efirst < 0) efirst = i;
                ef++;
            end
            s = lfsr_step(s);
        end
        efirst16 = (efirst < 0) ? 16'hFFFF : efirst[15:0];
        mode[0] = 1;
        run_vec(0, 64, 64, da, nd, bc, ae);
        mode[0] = 0;
        checks++; if (fail_o[0] !== ef[15:0]) begin errors++; $display("FAIL stuck_fail: got %0d required %0d", fail_o[0], ef); end
        checks++; if (pass_o[0] !== 16'(64 - ef)) begin errors++; $display("FAIL stuck_pass: got %0d required %0d", pass_o[0], 64 - ef); end
        checks++; if (ffi_o[0] !== efirst16) begin errors++; $display("FAIL stuck_first_fail: got %0d required %0d", ffi_o[0], efirst16); end
        checks++; if (da !== 66) begin errors++; $display("FAIL stuck_done_at: got %0d required 66", da); end
    endtask

    task automatic test_fault();
        int da, nd, bc, ae;
        mode[1] = 2; fidx[1] = 37;
        run_vec(1, 100, 100, da, nd, bc, ae);
        mode[1] = 0;
        checks++; if (fail_o[1] !== 16'd1) begin errors++; $display("FAIL fault_fail: got %0d required 1", fail_o[1]); end
        checks++; if (pass_o[1] !== 16'd99) begin errors++; $display("FAIL fault_pass: got %0d required 99", pass_o[1]); end
        checks++; if (ffi_o[1] !== 16'd37) begin errors++; $display("FAIL fault_first_fail: got %0d required 37", ffi_o[1]); end
        checks++; if (da !== 104) begin errors++; $display("FAIL fault_done_at: got %0d required 104", da); end
        checks++; if (ae !== 0) begin errors++; $display("FAIL fault_ab_seq: got %0d bad cycles required 0", ae); end
    endtask

    task automatic test_stop_on_fail();
        int da, nd, bc, ae;
`ifdef AND_STIM_STOP_ON_FAIL_EN
        int drv = 12;
        int epass = 11;
        int edone = 15;
`else
        int drv = 100;
        int epass = 99;
        int edone = 103;
`endif
        mode[2] = 2; fidx[2] = 10;
        run_vec(2, 100, drv, da, nd, bc, ae);
        mode[2] = 0;
        checks++; if (fail_o[2] !== 16'd1) begin errors++; $display("FAIL stop_fail: got %0d required 1", fail_o[2]); end
        checks++; if (pass_o[2] !== epass[15:0]) begin errors++; $display("FAIL stop_pass: got %0d required %0d", pass_o[2], epass); end
        checks++; if (ffi_o[2] !== 16'd10) begin errors++; $display("FAIL stop_first_fail: got %0d required 10", ffi_o[2]); end
        checks++; if (da !== edone) begin errors++; $display("FAIL stop_done_at: got %0d required %0d", da, edone); end
        checks++; if (ae !== 0) begin errors++; $display("FAIL stop_ab_seq: got %0d bad cycles required 0", ae); end
    endtask

    task automatic test_back_to_back();
        int da, nd, bc, ae;
        int ndone = 0;
        int rec_err = 0;
        logic ra [1:30];
        logic rb [1:30];
        logic [15:0] s;
        do_reset();
        mode[0] = 0;
        @(negedge clk);
        st[0] = 1'b1;
        nv[0] = 16'd50;
        for (int j = 0; j <= 37; j++) begin
            @(negedge clk);
            if (j == 0)  st[0] = 1'b0;
            if (j == 21) st[0] = 1'b1;
            if (j == 22) st[0] = 1'b0;
            if (j >= 1 && j <= 30) begin ra[j] = a_o[0]; rb[j] = b_o[0]; end
            if (done_o[0]) ndone++;
            if (j == 30) begin
                checks++;
                if (pass_o[0] !== 16'd29) begin errors++; $display("FAIL restart_ignored_pass: got %0d required 29", pass_o[0]); end
            end
            if (j == 31) rst = 1'b1;
            if (j == 32) begin
                rst = 1'b0;
                checks++;
                if ({a_o[0], b_o[0], busy_o[0], done_o[0], pass_o[0], fail_o[0], ffi_o[0]} !==
                    {4'b0000, 16'h0000, 16'h0000, 16'hFFFF}) begin
                    errors++;
                    $display("FAIL abort_reset_state: got %b/%b/%b/%b %h %h %h required 0/0/0/0 0000 0000 ffff",
                             a_o[0], b_o[0], busy_o[0], done_o[0], pass_o[0], fail_o[0], ffi_o[0]);
                end
            end
        end
        checks++; if (ndone !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses required 0", ndone); end

        s = 16'hACE1;
        for (int j = 1; j <= 30; j++) begin
            if (ra[j] !== s[0] || rb[j] !== s[1]) rec_err++;
            s = lfsr_step(s);
        end
        checks++; if (rec_err !== 0) begin errors++; $display("FAIL abort_first_seq: got %0d bad vectors required 0", rec_err); end

        for (int g = 0; g < NI; g++) mlf[g] = 16'hACE1;
        run_vec(0, 50, 50, da, nd, bc, ae);
        checks++; if (ae !== 0) begin errors++; $display("FAIL rerun_seq_from_seed: got %0d bad cycles required 0", ae); end
        checks++; if (pass_o[0] !== 16'd50) begin errors++; $display("FAIL rerun_pass: got %0d required 50", pass_o[0]); end
        checks++; if (da !== 52) begin errors++; $display("FAIL rerun_done_at: got %0d required 52", da); end
    endtask

    initial begin
        for (int g = 0; g < NI; g++) begin
            st[g] = 1'b0; nv[g] = 16'd0; mode[g] = 0; fidx[g] = 0; mlf[g] = 16'hACE1;
        end
        test_reset();
        test_ideal();
        test_zero();
        test_stuck();
        test_fault();
        test_stop_on_fail();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
